// File: rtl/pipe_run_ctrl.sv
// Run/step/breakpoint controller producing the single global pipeline enable for the 5-stage CPU.
// cpu_en is combinational from state and the breakpoint compare; commands are accepted when cmd_ready (never in STEP).
module pipe_run_ctrl #(
   parameter logic RUN_ON_RESET = 1'b1,
   parameter int   CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [31:0]      cmd_arg,
   input  logic [31:0]      pc_IF,
   input  logic             ext_halt,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic [2:0]       halt_cause,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [31:0]      bp_addr_o,
   output logic             bp_en_o
);

   typedef enum logic [1:0] {
      ST_HALTED = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10
   } state_t;

   localparam logic [1:0] OP_HALT   = 2'b00;
   localparam logic [1:0] OP_RUN    = 2'b01;
   localparam logic [1:0] OP_STEP   = 2'b10;
   localparam logic [1:0] OP_SET_BP = 2'b11;

   localparam logic [2:0] CAUSE_RESET = 3'd0;
   localparam logic [2:0] CAUSE_CMD   = 3'd1;
   localparam logic [2:0] CAUSE_STEP  = 3'd2;
   localparam logic [2:0] CAUSE_BP    = 3'd3;
   localparam logic [2:0] CAUSE_EXT   = 3'd4;

   state_t           state_q;
   logic [CNT_W-1:0] step_cnt;
   logic [CNT_W-1:0] step_arg;
   logic             skip;
   logic             bp_hit;
   logic             cmd_acc;
   logic             unused_ok;

   assign unused_ok = ^{cmd_arg[1], pc_IF[1:0]};
   assign state     = state_q;
   assign step_arg  = CNT_W'(cmd_arg);
   assign cmd_ready = (state_q != ST_STEP);
   assign cmd_acc   = cmd_valid & cmd_ready;

   // skip masks the breakpoint for the first enabled cycle after resuming, so we execute past it
   assign bp_hit = bp_en_o & (pc_IF[31:2] == bp_addr_o[31:2]) & ~skip;
   assign cpu_en = ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~bp_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN_ON_RESET ? ST_RUN : ST_HALTED;
         halt_cause <= CAUSE_RESET;
         cyc_cnt    <= '0;
         step_cnt   <= '0;
         bp_addr_o  <= '0;
         bp_en_o    <= 1'b0;
         skip       <= 1'b1;
      end else begin
         if (cpu_en) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            skip    <= 1'b0;
         end

         if (cmd_acc && cmd_op == OP_SET_BP) begin
            bp_addr_o <= {cmd_arg[31:2], 2'b00};
            bp_en_o   <= cmd_arg[0];
         end

         unique case (state_q)
            ST_HALTED: begin
               if (cmd_acc && cmd_op == OP_RUN) begin
                  state_q <= ST_RUN;
                  skip    <= 1'b1;
               end else if (cmd_acc && cmd_op == OP_STEP) begin
                  if (step_arg != '0) begin
                     state_q  <= ST_STEP;
                     step_cnt <= step_arg;
                     skip     <= 1'b1;
                  end else begin
                     halt_cause <= CAUSE_STEP;
                  end
               end
            end
            ST_RUN: begin
               if (bp_hit) begin
                  state_q    <= ST_HALTED;
                  halt_cause <= CAUSE_BP;
               end else if (ext_halt) begin
                  state_q    <= ST_HALTED;
                  halt_cause <= CAUSE_EXT;
               end else if (cmd_acc && cmd_op == OP_HALT) begin
                  state_q    <= ST_HALTED;
                  halt_cause <= CAUSE_CMD;
               end
            end
            ST_STEP: begin
               if (bp_hit) begin
                  state_q    <= ST_HALTED;
                  halt_cause <= CAUSE_BP;
                  step_cnt   <= '0;
               end else begin
                  // in STEP, no bp_hit means this edge is enabled
                  step_cnt <= step_cnt - CNT_W'(1);
                  if (ext_halt) begin
                     state_q    <= ST_HALTED;
                     halt_cause <= CAUSE_EXT;
                  end else if (step_cnt == CNT_W'(1)) begin
                     state_q    <= ST_HALTED;
                     halt_cause <= CAUSE_STEP;
                  end
               end
            end
            default: state_q <= ST_HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: per-cycle expected cpu_en/cmd_ready go through a scoreboard queue,
// status outputs are checked at checkpoints against bench-tracked expectations.
module tb_pipe_run_ctrl;

   localparam logic [1:0] OP_HALT   = 2'b00;
   localparam logic [1:0] OP_RUN    = 2'b01;
   localparam logic [1:0] OP_STEP   = 2'b10;
   localparam logic [1:0] OP_SET_BP = 2'b11;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic [31:0] pc_IF;
   logic        ext_halt;
   logic        cpu_en;
   logic [1:0]  state;
   logic [2:0]  halt_cause;
   logic [31:0] cyc_cnt;
   logic [31:0] bp_addr_o;
   logic        bp_en_o;

   logic        h_cmd_ready;
   logic        h_cpu_en;
   logic [1:0]  h_state;
   logic [2:0]  h_halt_cause;
   logic [31:0] h_cyc_cnt;
   logic [31:0] h_bp_addr_o;
   logic        h_bp_en_o;

   typedef struct {
      logic en;
      logic rdy;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc_no = 0;
   logic [31:0] exp_cyc = '0;

   pipe_run_ctrl #(.RUN_ON_RESET(1'b1), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_IF(pc_IF), .ext_halt(ext_halt),
      .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause), .cyc_cnt(cyc_cnt),
      .bp_addr_o(bp_addr_o), .bp_en_o(bp_en_o)
   );

   pipe_run_ctrl #(.RUN_ON_RESET(1'b0), .CNT_W(32)) u_dut_halt (
      .clk(clk), .rst(rst), .cmd_valid(1'b0), .cmd_ready(h_cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_IF(pc_IF), .ext_halt(1'b0),
      .cpu_en(h_cpu_en), .state(h_state), .halt_cause(h_halt_cause), .cyc_cnt(h_cyc_cnt),
      .bp_addr_o(h_bp_addr_o), .bp_en_o(h_bp_en_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("cpu_en", {63'd0, cpu_en}, {63'd0, e.en});
         chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, e.rdy});
      end
   end

   // One clock cycle with the currently driven inputs; called just after a rising edge.
   task automatic cyc(input logic en, input logic rdy);
      exp_t e;
      e.en  = en;
      e.rdy = rdy;
      sb_q.push_back(e);
      if (en) exp_cyc = exp_cyc + 32'd1;
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] arg, input logic en, input logic rdy);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      cyc(en, rdy);
      cmd_valid = 1'b0;
      cmd_arg   = '0;
   endtask

   task automatic chk_status(input string tag, input logic [1:0] st, input logic [2:0] cause);
      chk({tag, ".state"}, {62'd0, state}, {62'd0, st});
      chk({tag, ".cause"}, {61'd0, halt_cause}, {61'd0, cause});
      chk({tag, ".cyc_cnt"}, {32'd0, cyc_cnt}, {32'd0, exp_cyc});
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_HALT;
      cmd_arg   = '0;
      pc_IF     = '0;
      ext_halt  = 1'b0;

      @(posedge clk);
      #1;
      chk("rst.state", {62'd0, state}, 64'd1);
      chk("rst.cause", {61'd0, halt_cause}, 64'd0);
      chk("rst.cyc", {32'd0, cyc_cnt}, 64'd0);
      chk("rst.bp", {31'd0, bp_en_o, bp_addr_o}, 64'd0);
      chk("rst.cpu_en", {63'd0, cpu_en}, 64'd1);
      chk("rst0.state", {62'd0, h_state}, 64'd0);
      chk("rst0.cpu_en", {63'd0, h_cpu_en}, 64'd0);
      chk("rst0.ready", {63'd0, h_cmd_ready}, 64'd1);
      rst = 1'b0;

      // free run after reset
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
      chk("run10.cyc", {32'd0, cyc_cnt}, 64'd10);
      chk_status("run10", 2'b01, 3'd0);
      chk("halt_inst.cyc", {32'd0, h_cyc_cnt}, 64'd0);

      // async reset mid-run clears the counter immediately
      rst = 1'b1;
      #1;
      chk("midrst.cyc", {32'd0, cyc_cnt}, 64'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      exp_cyc = '0;

      // HALT alone: presenting cycle is still enabled and counted
      send(OP_HALT, 32'd0, 1'b1, 1'b1);
      chk_status("halt", 2'b00, 3'd1);
      cyc(1'b0, 1'b1);

      // STEP 3: exactly three enabled cycles, not ready throughout
      send(OP_STEP, 32'd3, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk_status("step3", 2'b00, 3'd2);

      // HALT and ext_halt together in RUN: ext_halt wins
      send(OP_RUN, 32'd0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      ext_halt = 1'b1;
      send(OP_HALT, 32'd0, 1'b1, 1'b1);
      ext_halt = 1'b0;
      chk_status("exthalt", 2'b00, 3'd4);

      // STEP 0 stays halted but reports step done
      send(OP_STEP, 32'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk_status("step0", 2'b00, 3'd2);

      // breakpoint at 0x10
      send(OP_SET_BP, 32'h0000_0011, 1'b0, 1'b1);
      chk("bp.addr", {32'd0, bp_addr_o}, 64'h10);
      chk("bp.en", {63'd0, bp_en_o}, 64'd1);
      pc_IF = 32'h0;
      send(OP_RUN, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1);
         pc_IF = pc_IF + 32'd4;
      end
      cyc(1'b0, 1'b1);
      chk_status("bp_run", 2'b00, 3'd3);
      chk("bp_run.cyc", {32'd0, cyc_cnt}, {32'd0, 32'd4 + 32'd1 + 32'd3 + 32'd1 + 32'd1});

      // resume runs past the breakpoint
      send(OP_RUN, 32'd0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      pc_IF = 32'h14;
      cyc(1'b1, 1'b1);
      pc_IF = 32'h18;
      send(OP_HALT, 32'd0, 1'b1, 1'b1);
      chk_status("resume", 2'b00, 3'd1);

      // STEP 5 with breakpoint reached on the third cycle
      pc_IF = 32'h8;
      send(OP_STEP, 32'd5, 1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      pc_IF = 32'hC;
      cyc(1'b1, 1'b0);
      pc_IF = 32'h10;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      chk_status("step_bp", 2'b00, 3'd3);

      // STEP 1 steps past the breakpoint
      send(OP_STEP, 32'd1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      pc_IF = 32'h14;
      cyc(1'b0, 1'b1);
      chk_status("step1", 2'b00, 3'd2);

      // ext_halt during STEP
      send(OP_STEP, 32'd4, 1'b0, 1'b1);
      pc_IF = 32'h18;
      cyc(1'b1, 1'b0);
      ext_halt = 1'b1;
      cyc(1'b1, 1'b0);
      ext_halt = 1'b0;
      cyc(1'b0, 1'b1);
      chk_status("step_ext", 2'b00, 3'd4);

      // counter wrap
      force u_dut.cyc_cnt = 32'hFFFF_FFFE;
      #1;
      release u_dut.cyc_cnt;
      exp_cyc = 32'hFFFF_FFFE;
      pc_IF   = 32'h100;
      send(OP_RUN, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
      chk("wrap.cyc", {32'd0, cyc_cnt}, 64'd1);
      chk_status("wrap", 2'b01, 3'd4);

      @(negedge clk);
      #1;
      chk("sb_drained", {32'd0, 32'(sb_q.size())}, 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
